butterfly_stage: RTL and testbench
==================================

Name: butterfly_stage

Overview:
- Fully parallel, pipelined 8-point radix-2 decimation-in-time FFT core.
- Accepts one frame of 8 complex samples per clock and emits one 8-bin spectrum per clock.
- Sits between the sample-framing logic and spectrum post-processing in the FFT datapath.
- Fixed-point, two's complement, no block scaling.

Parameters:
- DW, 25: width of each real/imag component.
- TW_FRAC, 15: fractional bits of twiddle constant √2/2 (value 23170).

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous reset, active-low (0 = reset)
- signal  input  8 x 50 (unpacked [7:0] of [49:0])  time-domain samples x[0..7], natural order
- final_stage  output  8 x 50 (unpacked [7:0] of [49:0])  frequency bins X[0..7], natural order

Behaviour:
- Word format for every element: [49:25] = real part, [24:0] = imaginary part, both two's complement DW bits.
- Reset:
  - While rst_i=0, all pipeline registers and final_stage clear to 0 asynchronously.
  - Release is synchronous to the next clk_i edge.
  - Reset mid-operation discards all in-flight frames.
- Input reordering: inputs are permuted in bit-reversed order before stage 1: 0,4,2,6,1,5,3,7.
- Stage 1: four 2-point butterflies on pairs (0,1),(2,3),(4,5),(6,7) of the reordered data.
  - A' = A+B, B' = A-B; twiddle W8^0.
- Stage 2: span 2.
  - Pairs (0,2),(1,3),(4,6),(5,7).
  - Twiddle W8^0 on the first pair of each group, W8^2 = -j on the second.
- Stage 3: span 4.
  - Pairs (k,k+4), k=0..3, with twiddles W8^0, W8^1, W8^2, W8^3 respectively.
- Twiddle arithmetic, applied to the lower element B before add/sub:
  - W8^0: B unchanged.
  - W8^2: (re,im) -> (im, -re).
  - W8^1: re' = R(c*(re+im)), im' = R(c*(im-re)).
  - W8^3: re' = R(c*(im-re)), im' = R(-c*(re+im)).
  - c = 23170. R(p) = (p + 2^14) >>> 15 (round half-up, arithmetic shift).
  - Intermediate sums are computed at DW+1 bits, products at full width, then truncated to DW.
- Width rule:
  - No bit growth at outputs; every add/sub/product result wraps modulo 2^DW.
  - Callers keep input magnitude < 2^(DW-4) to avoid overflow.
- Pipeline:
  - Each stage output is registered (3 register ranks).
  - Latency is 3 clk_i cycles from the edge sampling signal to final_stage valid.
  - Throughput is one frame per cycle; no handshake, no stall.
- No output gating:
  - After reset release, final_stage shows the transform of whatever was on signal 3 edges earlier.
  - Undriven (X) inputs propagate as X.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with nonzero signal -> final_stage all 0.
- Reset mid-stream: drop rst_i with frames in flight -> final_stage goes 0 immediately, without waiting for a clock edge.
- Impulse: x0 = 1+1j, others 0 -> all 8 bins = 1+1j after 3 cycles.
- DC: all xk = 1+0j -> X0 = 8+0j, X1..X7 = 0.
- Shifted impulse: x1 = 1000+0j, others 0 -> results by bin:
  - X0 = 1000
  - X1 = 707-707j
  - X2 = -1000j
  - X3 = -707-707j
  - X4 = -1000
  - X5 = -707+707j
  - X6 = +1000j
  - X7 = 707+707j
- Alternating: xk = (+1000,-1000,...) real -> X4 = 8000, all other bins 0.
- Pipelining: apply three different frames on consecutive cycles -> three correct spectra on consecutive cycles, in order, with no bubbles.

Source files
------------

// File: rtl/butterfly_stage.sv
// Pipelined 8-point radix-2 DIT FFT. One frame of 8 complex samples enters
// per clock, and one 8-bin spectrum leaves per clock, three register ranks later.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous reset, active-low; clears every pipeline rank
//   signal       time-domain samples x[0..7], natural order, {re, im} per word
//   final_stage  frequency bins X[0..7], natural order, {re, im} per word
//
// All arithmetic is two's complement at DW bits and wraps. The core applies
// no scaling, so callers must keep input magnitudes below 2^(DW-4).
module butterfly_stage #(
  parameter int unsigned DW      = 25,
  parameter int unsigned TW_FRAC = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*DW-1:0]     signal      [7:0],
  output logic [2*DW-1:0]     final_stage [7:0]
);

  localparam int unsigned WW = 2 * DW;
  // Product width: a (DW+1)-bit sum times a (TW_FRAC+1)-bit signed constant.
  localparam int unsigned PW = DW + TW_FRAC + 2;
  // The constant is sqrt(2)/2 in Q(TW_FRAC).
  localparam logic signed [PW-1:0] TW_C = PW'(23170);
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW_FRAC - 1));

  // Complex add, with each component wrapping modulo 2^DW.
  function automatic logic [WW-1:0] cadd(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    r = a[WW-1:DW] + b[WW-1:DW];
    i = a[DW-1:0] + b[DW-1:0];
    return {r, i};
  endfunction

  // Complex subtract, with each component wrapping modulo 2^DW.
  function automatic logic [WW-1:0] csub(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    r = a[WW-1:DW] - b[WW-1:DW];
    i = a[DW-1:0] - b[DW-1:0];
    return {r, i};
  endfunction

  // Multiply the lower butterfly input by W8^e.
  // The sums are widened by one bit and the products are kept at full width.
  // Rounding is half-up: add 2^(TW_FRAC-1), then shift arithmetically.
  // R(-p) differs from -R(p), so the -c*(re+im) term is rounded on its own.
  function automatic logic [WW-1:0] twiddle(input logic [WW-1:0] b, input logic [1:0] e);
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] nre;
    logic signed [DW:0]   s_sum;
    logic signed [DW:0]   s_dif;
    logic signed [PW-1:0] p_sum;
    logic signed [PW-1:0] p_dif;
    logic signed [DW-1:0] r_sum;
    logic signed [DW-1:0] r_dif;
    logic signed [DW-1:0] r_nsum;
    logic [WW-1:0]        res;
    re     = signed'(b[WW-1:DW]);
    im     = signed'(b[DW-1:0]);
    nre    = -re;
    s_sum  = (DW+1)'(re) + (DW+1)'(im);
    s_dif  = (DW+1)'(im) - (DW+1)'(re);
    p_sum  = PW'(s_sum) * TW_C;
    p_dif  = PW'(s_dif) * TW_C;
    r_sum  = DW'((p_sum + HALF) >>> TW_FRAC);
    r_dif  = DW'((p_dif + HALF) >>> TW_FRAC);
    r_nsum = DW'((HALF - p_sum) >>> TW_FRAC);
    case (e)
      2'd0:    res = b;
      2'd1:    res = {r_sum, r_dif};
      2'd2:    res = {im, nre};
      default: res = {r_dif, r_nsum};
    endcase
    return res;
  endfunction

  logic [WW-1:0] s1_d [8];
  logic [WW-1:0] s1_q [8];
  logic [WW-1:0] s2_d [8];
  logic [WW-1:0] s2_q [8];
  logic [WW-1:0] s3_d [8];
  logic [WW-1:0] tw2  [2];
  logic [WW-1:0] tw3  [4];

  // Stage 1. The bit-reversed order 0,4,2,6,1,5,3,7 pairs as (0,4),(2,6),(1,5),(3,7).
  always_comb begin
    s1_d[0] = cadd(signal[0], signal[4]);
    s1_d[1] = csub(signal[0], signal[4]);
    s1_d[2] = cadd(signal[2], signal[6]);
    s1_d[3] = csub(signal[2], signal[6]);
    s1_d[4] = cadd(signal[1], signal[5]);
    s1_d[5] = csub(signal[1], signal[5]);
    s1_d[6] = cadd(signal[3], signal[7]);
    s1_d[7] = csub(signal[3], signal[7]);
  end

  // Stage 2, span 2. The second pair of each group of four takes -j.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      tw2[g] = '0;
      s2_d[4*g]   = '0;
      s2_d[4*g+1] = '0;
      s2_d[4*g+2] = '0;
      s2_d[4*g+3] = '0;
    end
    for (int g = 0; g < 2; g++) begin
      tw2[g]      = twiddle(s1_q[4*g+3], 2'd2);
      s2_d[4*g]   = cadd(s1_q[4*g],   s1_q[4*g+2]);
      s2_d[4*g+2] = csub(s1_q[4*g],   s1_q[4*g+2]);
      s2_d[4*g+1] = cadd(s1_q[4*g+1], tw2[g]);
      s2_d[4*g+3] = csub(s1_q[4*g+1], tw2[g]);
    end
  end

  // Stage 3, span 4. Pair k takes W8^k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      tw3[k]    = '0;
      s3_d[k]   = '0;
      s3_d[k+4] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      tw3[k]    = twiddle(s2_q[k+4], 2'(k));
      s3_d[k]   = cadd(s2_q[k], tw3[k]);
      s3_d[k+4] = csub(s2_q[k], tw3[k]);
    end
  end

  // Three register ranks with no gating. Reset drops every frame in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int n = 0; n < 8; n++) begin
        s1_q[n]        <= '0;
        s2_q[n]        <= '0;
        final_stage[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        s1_q[n]        <= s1_d[n];
        s2_q[n]        <= s2_d[n];
        final_stage[n] <= s3_d[n];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_stage.sv
module tb_butterfly_stage;

  localparam int unsigned DW = 25;
  localparam int unsigned WW = 2 * DW;
  localparam int unsigned FW = 8 * WW;

  logic          clk_i;
  logic          rst_i;
  logic [WW-1:0] signal      [7:0];
  logic [WW-1:0] final_stage [7:0];

  int total;
  int bad;
  int edge_cnt;

  logic [FW-1:0] exp_q [$];
  int            due_q [$];

  butterfly_stage #(.DW(DW), .TW_FRAC(15)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .signal      (signal),
    .final_stage (final_stage)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint wrap(input longint x);
    logic [63:0] t;
    t = x;
    return sx(t[DW-1:0]);
  endfunction

  function automatic longint rnd(input longint p);
    return (p + 64'sd16384) >>> 15;
  endfunction

  // Build one frame from integer components.
  function automatic logic [FW-1:0] mk(input int re [8], input int im [8]);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i*WW +: WW] = {DW'(re[i]), DW'(im[i])};
    return f;
  endfunction

  // Reference FFT: bit-reverse the inputs, then three spans with W8^e twiddles and DW-bit wrap.
  function automatic logic [FW-1:0] ref_fft(input logic [FW-1:0] f);
    int     rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    longint re [8];
    longint im [8];
    longint br;
    longint bi;
    longint ar;
    longint ai;
    longint c;
    int     e;
    logic [FW-1:0] o;
    c = 23170;
    for (int i = 0; i < 8; i++) begin
      re[i] = sx(f[rev[i]*WW + DW +: DW]);
      im[i] = sx(f[rev[i]*WW +: DW]);
    end
    for (int span = 1; span < 8; span = span * 2) begin
      for (int base = 0; base < 8; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          e  = j * (4 / span);
          ar = re[base+j];
          ai = im[base+j];
          br = re[base+j+span];
          bi = im[base+j+span];
          case (e)
            1: begin
              br = wrap(rnd(c * (re[base+j+span] + im[base+j+span])));
              bi = wrap(rnd(c * (im[base+j+span] - re[base+j+span])));
            end
            2: begin
              br = im[base+j+span];
              bi = wrap(-re[base+j+span]);
            end
            3: begin
              br = wrap(rnd(c * (im[base+j+span] - re[base+j+span])));
              bi = wrap(rnd(-c * (re[base+j+span] + im[base+j+span])));
            end
            default: ;
          endcase
          re[base+j]      = wrap(ar + br);
          im[base+j]      = wrap(ai + bi);
          re[base+j+span] = wrap(ar - br);
          im[base+j+span] = wrap(ai - bi);
        end
      end
    end
    for (int i = 0; i < 8; i++) o[i*WW +: WW] = {DW'(re[i]), DW'(im[i])};
    return o;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    int re [8];
    int im [8];
    for (int i = 0; i < 8; i++) begin
      re[i] = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
      im[i] = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
    end
    return mk(re, im);
  endfunction

  // Pop and compare every expected spectrum that is due after this edge.
  task automatic score();
    logic [FW-1:0] e;
    while (due_q.size() > 0 && due_q[0] <= edge_cnt) begin
      e = exp_q.pop_front();
      if (due_q.pop_front() != edge_cnt) begin
        total++;
        bad++;
        $display("FAIL late_frame got=edge%0d exp=earlier", edge_cnt);
      end else begin
        for (int i = 0; i < 8; i++) chk($sformatf("bin%0d", i), final_stage[i], e[i*WW +: WW]);
      end
    end
  endtask

  // One cycle: score at the negedge, drive the next frame, then queue its expected spectrum.
  task automatic step(input logic [FW-1:0] frame, input logic [FW-1:0] exp);
    @(negedge clk_i);
    score();
    for (int i = 0; i < 8; i++) signal[i] = frame[i*WW +: WW];
    exp_q.push_back(exp);
    due_q.push_back(edge_cnt + 3);
  endtask

  task automatic step_rand();
    logic [FW-1:0] f;
    f = rand_frame();
    step(f, ref_fft(f));
  endtask

  initial begin
    int re [8];
    int im [8];
    int xr [8];
    int xi [8];
    logic [FW-1:0] f;

    total    = 0;
    bad      = 0;
    edge_cnt = 0;
    rst_i    = 1'b0;
    for (int i = 0; i < 8; i++) signal[i] = {DW'(i + 3), DW'(100 - i)};

    // Hold reset for 2 cycles while the input is nonzero.
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 8; i++) chk($sformatf("reset_bin%0d", i), final_stage[i], '0);
    rst_i = 1'b1;

    // Impulse 1+1j: every bin is 1+1j.
    re = '{1, 0, 0, 0, 0, 0, 0, 0};
    im = '{1, 0, 0, 0, 0, 0, 0, 0};
    xr = '{1, 1, 1, 1, 1, 1, 1, 1};
    xi = '{1, 1, 1, 1, 1, 1, 1, 1};
    step(mk(re, im), mk(xr, xi));

    // DC input: X0 = 8, every other bin is 0.
    re = '{1, 1, 1, 1, 1, 1, 1, 1};
    im = '{0, 0, 0, 0, 0, 0, 0, 0};
    xr = '{8, 0, 0, 0, 0, 0, 0, 0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    step(mk(re, im), mk(xr, xi));

    // Shifted impulse x1 = 1000.
    re = '{0, 1000, 0, 0, 0, 0, 0, 0};
    im = '{0, 0, 0, 0, 0, 0, 0, 0};
    xr = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    xi = '{0, -707, -1000, -707, 0, 707, 1000, 707};
    step(mk(re, im), mk(xr, xi));

    // Alternating +-1000: X4 = 8000, every other bin is 0.
    re = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000};
    im = '{0, 0, 0, 0, 0, 0, 0, 0};
    xr = '{0, 0, 0, 0, 8000, 0, 0, 0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    step(mk(re, im), mk(xr, xi));

    // Back-to-back random frames.
    repeat (6) step_rand();

    // Drop reset mid-cycle while frames are in flight.
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("midrst_bin%0d", i), final_stage[i], '0);
    exp_q.delete();
    due_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Streaming resumes cleanly after the reset.
    repeat (5) step_rand();
    f = rand_frame();
    step(f, ref_fft(f));

    // Drain the pipeline with a bounded number of cycles.
    for (int n = 0; n < 6 && due_q.size() > 0; n++) begin
      @(negedge clk_i);
      score();
    end
    if (due_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending exp=0", due_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
